// File: rtl/robm_key_sequencer.sv
// Serial key-entry controller guarding the locked robm FSM: shifts in a key MSB-first,
// releases the FSM with the correct key input on a match, and enforces a timed lockout.
module robm_key_sequencer #(
    parameter int unsigned      KEY_W      = 8,
    parameter logic [KEY_W-1:0] KEY_VAL    = KEY_W'(8'hA5),
    parameter logic             KEY_OK_BIT = 1'b0,
    parameter int unsigned      MAX_FAIL   = 3,
    parameter int unsigned      LOCK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic       key_bit,
    output logic       key_ready,
    output logic       key_out,
    output logic       fsm_rst,
    output logic       unlocked,
    output logic       fail,
    output logic       locked_out,
    output logic [3:0] fail_cnt
);

    localparam int unsigned CNT_W = $clog2(KEY_W);
    localparam int unsigned TMR_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_GRANT,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TMR_W-1:0]   lock_tmr;
    logic [3:0]         fail_nxt;

    // Mismatch count after this failure, saturating at MAX_FAIL
    assign fail_nxt = (fail_cnt == 4'(MAX_FAIL)) ? fail_cnt : fail_cnt + 4'd1;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            lock_tmr   <= '0;
            key_ready  <= 1'b0;
            key_out    <= ~KEY_OK_BIT;
            fsm_rst    <= 1'b1;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= 4'd0;
        end else begin
            fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SHIFT;
                        sreg      <= '0;
                        bit_cnt   <= '0;
                        key_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (key_valid && key_ready) begin
                        sreg    <= {sreg[KEY_W-2:0], key_bit};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(KEY_W - 1)) begin
                            state     <= ST_CHECK;
                            key_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (sreg == KEY_VAL) begin
                        state    <= ST_GRANT;
                        fail_cnt <= 4'd0;
                        key_out  <= KEY_OK_BIT;
                        fsm_rst  <= 1'b0;
                        unlocked <= 1'b1;
                    end else begin
                        fail_cnt <= fail_nxt;
                        fail     <= 1'b1;
                        if (fail_nxt == 4'(MAX_FAIL)) begin
                            state      <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                            lock_tmr   <= '0;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end
                end
                ST_GRANT: begin
                    // Re-key: the locked FSM goes back into reset before any new bit arrives
                    if (start) begin
                        state     <= ST_SHIFT;
                        sreg      <= '0;
                        bit_cnt   <= '0;
                        key_ready <= 1'b1;
                        key_out   <= ~KEY_OK_BIT;
                        fsm_rst   <= 1'b1;
                        unlocked  <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    state <= ST_IDLE;
                end
                ST_LOCKOUT: begin
                    if (lock_tmr == TMR_W'(LOCK_CYC - 1)) begin
                        state      <= ST_IDLE;
                        fail_cnt   <= 4'd0;
                        locked_out <= 1'b0;
                    end else begin
                        lock_tmr <= lock_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robm_key_sequencer.sv
// Scoreboard bench for robm_key_sequencer: each key entry pushes its expected outcome,
// a monitor pops and compares it when the sequencer reports a match or a failure.
module tb_robm_key_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, key_valid, key_bit;
    logic       key_ready, key_out, fsm_rst, unlocked, fail, locked_out;
    logic [3:0] fail_cnt;

    robm_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .fsm_rst    (fsm_rst),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         match;
        logic [3:0] cnt;
        bit         lock;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         lock_cycles = 0;
    logic [3:0] model_cnt = 4'd0;
    bit         prev_unlocked = 1'b0;
    bit         prev_fail = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs move on the falling edge; observe them on the rising edge
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            prev_unlocked = 1'b0;
            prev_fail     = 1'b0;
        end else begin
            if (locked_out) lock_cycles++;
            if (fail) chk("fail_width", 32'(prev_fail), 32'd0);
            if (fail || (unlocked && !prev_unlocked)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("match",      32'(unlocked),   32'(e.match));
                    chk("fail_pulse", 32'(fail),       32'(!e.match));
                    chk("fail_cnt",   32'(fail_cnt),   32'(e.cnt));
                    chk("locked_out", 32'(locked_out), 32'(e.lock));
                    chk("key_out",    32'(key_out),    32'(!e.match));
                    chk("fsm_rst",    32'(fsm_rst),    32'(!e.match));
                end
            end
            prev_unlocked = unlocked;
            prev_fail     = fail;
        end
    end

    task automatic push_expect(input logic [7:0] k);
        exp_t e;
        if (k == 8'hA5) begin
            model_cnt = 4'd0;
            e = '{match: 1'b1, cnt: 4'd0, lock: 1'b0};
        end else begin
            model_cnt = model_cnt + 4'd1;
            if (model_cnt == 4'd3) begin
                e = '{match: 1'b0, cnt: 4'd3, lock: 1'b1};
                model_cnt = 4'd0;
            end else begin
                e = '{match: 1'b0, cnt: model_cnt, lock: 1'b0};
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic enter_key(input logic [7:0] k, input bit gaps);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        chk("shift_ready",   32'(key_ready), 32'd1);
        chk("shift_fsm_rst", 32'(fsm_rst),   32'd1);
        chk("shift_locked",  32'(unlocked),  32'd0);
        chk("shift_key_out", 32'(key_out),   32'd1);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                key_valid = 1'b0;
                key_bit   = ~k[i];
                @(posedge clk);
            end
            key_valid = 1'b1;
            key_bit   = k[i];
            if (gaps && i == 4) start = 1'b1;
            @(posedge clk);
            start = 1'b0;
        end
        key_valid = 1'b0;
        push_expect(k);
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("result_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_key_ready"},  32'(key_ready),  32'd0);
        chk({tag, "_key_out"},    32'(key_out),    32'd1);
        chk({tag, "_fsm_rst"},    32'(fsm_rst),    32'd1);
        chk({tag, "_unlocked"},   32'(unlocked),   32'd0);
        chk({tag, "_fail"},       32'(fail),       32'd0);
        chk({tag, "_locked_out"}, 32'(locked_out), 32'd0);
        chk({tag, "_fail_cnt"},   32'(fail_cnt),   32'd0);
    endtask

    initial begin
        logic [7:0] pk;
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Correct key unlocks
        enter_key(8'hA5, 1'b0);

        // Single wrong key: one failure, back to idle with the FSM held
        enter_key(8'hA4, 1'b0);
        chk("idle_ready",   32'(key_ready), 32'd0);
        chk("idle_key_out", 32'(key_out),   32'd1);
        chk("idle_fsm_rst", 32'(fsm_rst),   32'd1);

        // Clear the count, then three consecutive wrong keys
        enter_key(8'hA5, 1'b0);
        enter_key(8'h00, 1'b0);
        enter_key(8'hFF, 1'b0);
        enter_key(8'h5A, 1'b0);
        chk("lock_active", 32'(locked_out), 32'd1);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        for (int n = 0; n < 40 && locked_out; n++) @(posedge clk);
        chk("lock_expired", 32'(locked_out), 32'd0);
        @(posedge clk);
        chk("lock_len",       32'(lock_cycles), 32'd16);
        chk("lock_cnt_clear", 32'(fail_cnt),    32'd0);
        chk("lock_start_ign", 32'(key_ready),   32'd0);
        chk("lock_fsm_rst",   32'(fsm_rst),     32'd1);

        // Gapped key_valid with a stray start pulse mid-entry
        enter_key(8'hA5, 1'b1);

        // Reset after a partial key, then a clean entry
        pk = 8'hA5;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            key_valid = 1'b1;
            key_bit   = pk[i];
            @(posedge clk);
        end
        key_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        rst = 1'b0;
        model_cnt = 4'd0;
        enter_key(8'hA5, 1'b0);

        // Re-key from GRANT with a wrong key
        enter_key(8'h3C, 1'b0);

        repeat (5) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
